step_arbiter: RTL and testbench

Round-robin scheduler that shares a single step_controller instance (add -> mul -> special -> end chain) among N_REQ independent requesters. Each requester posts one byte and later receives that byte's processed result. The arbiter owns the controller's start/data_in handshake and routes data_out/done back to the granted requester. It sits between client blocks and one step_controller, and allows only one job in flight.

---
 rtl/step_arbiter.sv | 155 +++++++++++++++
 tb/tb_step_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_arbiter.sv
// step_arbiter: round-robin sharing of one step_controller among N_REQ requesters, one job in flight.
// Optional macro STEP_ARB_STATS_EN adds stat_cnt, a saturating 16-bit response counter per requester.
module step_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                busy,
    output logic                sc_start,
    output logic [DW-1:0]       sc_data_in,
    input  logic [DW-1:0]       sc_data_out,
    input  logic                sc_done
`ifdef STEP_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] stat_cnt
`endif
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              sc_start_q, sc_start_d;
    logic [DW-1:0]     sc_data_in_q, sc_data_in_d;

    logic              win_vld_c;
    logic [PW-1:0]     win_idx_c;

    // Winner = first requester at or after rr_q+1; scanning downward lets the nearest offset overwrite.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            idx = (32'(rr_q) + k) % N_REQ;
            if (req[PW'(idx)]) begin
                win_vld_c = 1'b1;
                win_idx_c = PW'(idx);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        busy_d       = busy_q;
        sc_start_d   = 1'b0;
        sc_data_in_d = sc_data_in_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (win_vld_c) begin
                    owner_d            = win_idx_c;
                    sc_data_in_d       = req_data[32'(win_idx_c)*DW +: DW];
                    gnt_d[win_idx_c]   = 1'b1;
                    sc_start_d         = 1'b1;
                    busy_d             = 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                busy_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy_d = 1'b1;
                if (sc_done) begin
                    rsp_data_d           = sc_data_out;
                    rsp_valid_d[owner_q] = 1'b1;
                    rr_d                 = owner_q;
                    busy_d               = 1'b0;
                    state_d              = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_q         <= PW'(N_REQ - 1);
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            sc_start_q   <= 1'b0;
            sc_data_in_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
            sc_start_q   <= sc_start_d;
            sc_data_in_q <= sc_data_in_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign sc_start   = sc_start_q;
    assign sc_data_in = sc_data_in_q;

`ifdef STEP_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] stat_q;

    // Counts delivered responses per requester, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (rsp_valid_q[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_step_arbiter.sv
// tb_step_arbiter: directed scoreboard bench for step_arbiter with a fixed-latency step_controller stub.
// Set STEP_ARB_STATS_EN to also exercise the response counters.
module tb_step_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [31:0]      req_data;
    logic [3:0]       gnt;
    logic [3:0]       rsp_valid;
    logic [7:0]       rsp_data;
    logic             busy;
    logic             sc_start;
    logic [7:0]       sc_data_in;
    logic [7:0]       sc_data_out;
    logic             sc_done;
    logic             stub_done;
    logic [7:0]       stub_data;
    logic             spur_done;
`ifdef STEP_ARB_STATS_EN
    logic [63:0]      stat_cnt;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         b2b;
    } gexp_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_gnt_cyc = 0;
    int last_rsp_cyc = 0;
    int gnt_seen = 0;

    assign sc_done     = stub_done | spur_done;
    assign sc_data_out = spur_done ? 8'hEE : stub_data;

    step_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .sc_start    (sc_start),
        .sc_data_in  (sc_data_in),
        .sc_data_out (sc_data_out),
        .sc_done     (sc_done)
`ifdef STEP_ARB_STATS_EN
        ,
        .stat_cnt    (stat_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // step_controller stub: result = operand + 0x11, done pulse 6 cycles after start
    initial begin
        logic [7:0] v;
        stub_done = 1'b0;
        stub_data = 8'h00;
        forever begin
            @(negedge clk);
            if (sc_start) begin
                v = sc_data_in + 8'h11;
                repeat (6) @(negedge clk);
                stub_data = v;
                stub_done = 1'b1;
                @(negedge clk);
                stub_done = 1'b0;
            end
        end
    end

    // Monitor: pops expected grants and responses as the DUT presents them
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 4'b0) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 32'h0);
                end else begin
                    gexp_t g;
                    logic [3:0] oh;
                    g  = gq.pop_front();
                    oh = 4'b0001 << g.idx;
                    check("gnt_onehot", 32'(gnt), 32'(oh));
                    check("gnt_sc_start", 32'(sc_start), 32'h1);
                    check("gnt_sc_data_in", 32'(sc_data_in), 32'(g.data));
                    check("gnt_busy", 32'(busy), 32'h1);
                    if (g.b2b) check("gnt_after_rsp", 32'(cyc - last_rsp_cyc), 32'd1);
                end
                last_gnt_cyc = cyc;
                gnt_seen++;
            end
            if (rsp_valid != 4'b0) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    rexp_t r;
                    logic [3:0] oh;
                    r  = rq.pop_front();
                    oh = 4'b0001 << r.idx;
                    check("rsp_onehot", 32'(rsp_valid), 32'(oh));
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                    check("rsp_busy", 32'(busy), 32'h0);
                    check("rsp_latency", 32'(cyc - last_gnt_cyc), 32'd7);
                end
                last_rsp_cyc = cyc;
            end
        end
    end

    task automatic push_job(input int idx, input logic [7:0] d, input bit b2b);
        gexp_t g;
        rexp_t r;
        g.idx = idx; g.data = d; g.b2b = b2b;
        r.idx = idx; r.data = d + 8'h11;
        gq.push_back(g);
        rq.push_back(r);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((gq.size() != 0 || rq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("quiet_timeout", 32'(gq.size() + rq.size()), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    // Raise mask, drop each bit in its grant cycle, then wait for all traffic to finish
    task automatic run_drop(input logic [3:0] mask);
        int n;
        req = mask;
        n = 0;
        while (req != 4'b0 && n < 300) begin
            @(negedge clk);
            req = req & ~gnt;
            n++;
        end
        if (n >= 300) check("grant_timeout", 32'(req), 32'h0);
        req = 4'b0;
        wait_quiet();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_sc_start"}, 32'(sc_start), 32'h0);
        check({tag, "_sc_data_in"}, 32'(sc_data_in), 32'h0);
    endtask

    initial begin
        int n;
        int target;
        rst = 1'b1; req = 4'b0; req_data = 32'h0; spur_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Single request on requester 2
        req_data = 32'h0020_0000;
        push_job(2, 8'h20, 1'b0);
        run_drop(4'b0100);

        // Simultaneous requests right after reset: order 0,1,2,3 back to back
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req_data = 32'h4030_2010;
        push_job(0, 8'h10, 1'b0);
        push_job(1, 8'h20, 1'b1);
        push_job(2, 8'h30, 1'b1);
        push_job(3, 8'h40, 1'b1);
        run_drop(4'b1111);

        // Fairness: requester 1 finishes, then 0 and 1 request continuously
        req_data = 32'h0000_C0A0;
        push_job(1, 8'hC0, 1'b0);
        run_drop(4'b0010);
        push_job(0, 8'hA0, 1'b0);
        push_job(1, 8'hC0, 1'b1);
        push_job(0, 8'hA0, 1'b1);
        push_job(1, 8'hC0, 1'b1);
        target = gnt_seen + 4;
        req = 4'b0011;
        n = 0;
        while (gnt_seen < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("fair_grants", 32'(gnt_seen), 32'(target));
        req = 4'b0;
        wait_quiet();

        // Withdrawn pulse on requester 3 while busy, then a spurious done in IDLE
        req_data = 32'h9900_0005;
        push_job(0, 8'h05, 1'b0);
        req = 4'b0001;
        n = 0;
        while (gnt[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req = 4'b0;
        repeat (2) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0;
        wait_quiet();
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (4) @(negedge clk);
        check("spurious_idle_busy", 32'(busy), 32'h0);

        // Reset three cycles after grant; the stub's late done must be discarded
        req_data = 32'h0000_7700;
        gq.push_back('{idx: 1, data: 8'h77, b2b: 1'b0});
        req = 4'b0010;
        n = 0;
        while (gnt[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req = 4'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midreset");
        repeat (8) @(negedge clk);
        check("midreset_late_done_busy", 32'(busy), 32'h0);
        req_data = 32'h0000_0100;
        push_job(1, 8'h01, 1'b0);
        run_drop(4'b0010);

`ifdef STEP_ARB_STATS_EN
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req_data = 32'h3300_0003;
        for (int i = 0; i < 5; i++) begin
            push_job(0, 8'h03, 1'b0);
            run_drop(4'b0001);
        end
        for (int i = 0; i < 2; i++) begin
            push_job(3, 8'h33, 1'b0);
            run_drop(4'b1000);
        end
        check("stat0", 32'(stat_cnt[15:0]), 32'd5);
        check("stat1", 32'(stat_cnt[31:16]), 32'd0);
        check("stat2", 32'(stat_cnt[47:32]), 32'd0);
        check("stat3", 32'(stat_cnt[63:48]), 32'd2);
        force dut.stat_q = {16'd2, 16'd0, 16'd0, 16'hFFFF};
        @(negedge clk);
        release dut.stat_q;
        push_job(0, 8'h03, 1'b0);
        run_drop(4'b0001);
        check("stat0_saturate", 32'(stat_cnt[15:0]), 32'h0000FFFF);
        check("stat3_after_sat", 32'(stat_cnt[63:48]), 32'd2);
`endif

        check("gnt_queue_empty", 32'(gq.size()), 32'h0);
        check("rsp_queue_empty", 32'(rq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
